// File: rtl/cnt_ctrl_pkg.sv
// Shared definitions for controllers that time-share a loadable up-counter.
// Holds the FSM state encoding, default sizes and a small index helper.
package cnt_ctrl_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_NREQ  = 4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_COUNT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_LOAD  = S_LOAD,
      ST_COUNT = S_COUNT,
      ST_DONE  = S_DONE
   } state_t;

   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/counter_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Kept standalone so other shared-resource arbiters can reuse it.
module rr_pick #(
   parameter  int NREQ = cnt_ctrl_pkg::DEF_NREQ,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            valid,
   output logic [IDW-1:0]  idx
);

   // Scan offsets from farthest to nearest so the nearest hit overwrites the rest.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NREQ]) begin
            valid = 1'b1;
            idx   = IDW'((int'(ptr) + k) % NREQ);
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/counter_share_ctrl.sv
// Time-shares one loadable up-counter among NREQ requesters, each asking for a
// d-cycle delay; round-robin grant, load with -d, count to carry-out, then ack.
module counter_share_ctrl
   import cnt_ctrl_pkg::*;
#(
   parameter  int NREQ  = DEF_NREQ,
   parameter  int WIDTH = DEF_WIDTH,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_val,
   input  logic                  cnt_co,
   output logic                  cnt_load,
   output logic                  cnt_en,
   output logic [WIDTH-1:0]      cnt_in,
   output logic [NREQ-1:0]       ack,
   output logic                  busy,
   output logic [IDW-1:0]        grant_id
);

   state_t            r_state;
   logic [IDW-1:0]    r_ptr;
   logic [IDW-1:0]    r_grant;
   logic              r_load;
   logic              r_en;
   logic              r_busy;
   logic [WIDTH-1:0]  r_cnt_in;
   logic [NREQ-1:0]   r_ack;

   logic              w_valid;
   logic [IDW-1:0]    w_idx;
   logic [WIDTH-1:0]  w_d;
   logic              w_req_g;
   logic [IDW-1:0]    w_next_ptr;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req),
      .ptr   (r_ptr),
      .valid (w_valid),
      .idx   (w_idx)
   );

   assign w_d        = req_val[int'(w_idx)*WIDTH +: WIDTH];
   assign w_req_g    = req[r_grant];
   assign w_next_ptr = IDW'(wrap_inc(int'(r_grant), NREQ));

   // The latched delay lives in r_cnt_in as its two's complement, ready for LOAD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_grant  <= '0;
         r_load   <= 1'b0;
         r_en     <= 1'b0;
         r_busy   <= 1'b0;
         r_cnt_in <= '0;
         r_ack    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_state  <= ST_LOAD;
                  r_grant  <= w_idx;
                  r_cnt_in <= -w_d;
                  r_load   <= 1'b1;
                  r_busy   <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_LOAD, ST_COUNT: begin
               if (!w_req_g) begin
                  r_state  <= ST_IDLE;
                  r_ptr    <= w_next_ptr;
                  r_grant  <= '0;
                  r_load   <= 1'b0;
                  r_en     <= 1'b0;
                  r_busy   <= 1'b0;
                  r_cnt_in <= '0;
               end else if (r_state == ST_LOAD) begin
                  r_state  <= ST_COUNT;
                  r_load   <= 1'b0;
                  r_en     <= 1'b1;
                  r_cnt_in <= '0;
               end else if (cnt_co) begin
                  r_state <= ST_DONE;
                  r_en    <= 1'b0;
                  r_ack   <= NREQ'(1) << r_grant;
               end else begin
                  r_state <= ST_COUNT;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_ptr   <= w_next_ptr;
               r_grant <= '0;
               r_ack   <= '0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_grant  <= '0;
               r_load   <= 1'b0;
               r_en     <= 1'b0;
               r_busy   <= 1'b0;
               r_cnt_in <= '0;
               r_ack    <= '0;
            end
         endcase
      end
   end

   assign cnt_load = r_load;
   assign cnt_en   = r_en;
   assign cnt_in   = r_cnt_in;
   assign ack      = r_ack;
   assign busy     = r_busy;
   assign grant_id = r_grant;

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Randomized bench for counter_share_ctrl: models the shared counter and predicts
// every output from a per-grant timeline (sample, load, d count cycles, ack).
module tb_counter_share_ctrl;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int IDW   = 2;
   localparam int VW    = NREQ * WIDTH;

   logic             clk = 1'b0;
   logic             rst;
   logic [NREQ-1:0]  req;
   logic [VW-1:0]    req_val;
   logic             cnt_co;
   logic             cnt_load;
   logic             cnt_en;
   logic [WIDTH-1:0] cnt_in;
   logic [NREQ-1:0]  ack;
   logic             busy;
   logic [IDW-1:0]   grant_id;
   logic [WIDTH-1:0] cnt_q;

   int checks = 0;
   int errors = 0;

   bit m_active;
   int m_t0, m_len, m_g, m_d, m_ptr, t;
   bit drop_next [NREQ];

   always #5 clk = ~clk;

   counter_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .req(req), .req_val(req_val), .cnt_co(cnt_co),
      .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_in(cnt_in), .ack(ack),
      .busy(busy), .grant_id(grant_id)
   );

   // the shared counter the controller drives
   always @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else if (cnt_load) cnt_q <= cnt_in;
      else if (cnt_en) cnt_q <= cnt_q + 1'b1;
   end
   assign cnt_co = (&cnt_q) & cnt_en;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, t, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string pfx);
      chk({pfx, "_busy"}, 32'(busy), 0);
      chk({pfx, "_en"}, 32'(cnt_en), 0);
      chk({pfx, "_load"}, 32'(cnt_load), 0);
      chk({pfx, "_ack"}, 32'(ack), 0);
      chk({pfx, "_grant"}, 32'(grant_id), 0);
   endtask

   // Predict this cycle's outputs from the grant timeline, then apply this cycle's decision.
   task automatic model_eval();
      int ph, e_load, e_en, e_ack, e_busy, e_gid, e_cin;
      int unsigned dbl, low, pos;
      ph = t - m_t0;
      e_load = 0; e_en = 0; e_ack = 0; e_busy = 0; e_gid = 0; e_cin = 0;
      if (m_active) begin
         e_busy = 1;
         e_gid  = m_g;
         e_load = (ph == 1) ? 1 : 0;
         e_cin  = (ph == 1) ? (16 - m_d) % 16 : 0;
         e_en   = (ph >= 2 && ph <= m_len + 1) ? 1 : 0;
         e_ack  = (ph == m_len + 2) ? (1 << m_g) : 0;
      end
      chk("cnt_load", 32'(cnt_load), e_load);
      chk("cnt_en", 32'(cnt_en), e_en);
      chk("cnt_in", 32'(cnt_in), e_cin);
      chk("ack", 32'(ack), e_ack);
      chk("busy", 32'(busy), e_busy);
      chk("grant_id", 32'(grant_id), e_gid);
      chk("load_en_excl", 32'(cnt_load & cnt_en), 0);

      if (!m_active) begin
         if (req != '0) begin
            dbl = 32'({req, req}) >> m_ptr;
            low = dbl & (~dbl + 1);
            pos = $clog2(low);
            m_g = (m_ptr + int'(pos)) % NREQ;
            m_d = int'(req_val >> (m_g * WIDTH)) & 15;
            m_len = (m_d == 0) ? 16 : m_d;
            m_t0 = t;
            m_active = 1'b1;
         end
      end else if (ph <= m_len + 1 && !req[m_g]) begin
         m_active = 1'b0;
         m_ptr = (m_g + 1) % NREQ;
      end else if (ph == m_len + 2) begin
         m_active = 1'b0;
         m_ptr = (m_g + 1) % NREQ;
         drop_next[m_g] = 1'b1;
      end
      t++;
   endtask

   task automatic stim_random();
      for (int i = 0; i < NREQ; i++) begin
         if (drop_next[i]) begin
            req[i] = 1'b0;
            drop_next[i] = 1'b0;
         end else if (req[i]) begin
            if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
         end
      end
      if ($urandom_range(0, 1) == 0) req_val = VW'($urandom);
   endtask

   task automatic run_cycle(input bit rnd, input logic [NREQ-1:0] r_in, input logic [VW-1:0] v_in);
      @(posedge clk);
      #1;
      if (rnd) stim_random();
      else begin
         req = r_in;
         req_val = v_in;
      end
      @(negedge clk);
      model_eval();
   endtask

   task automatic do_reset_mid();
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check_idle_outputs("async_rst");
      m_active = 1'b0;
      m_ptr = 0;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      model_eval();
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      req_val = '0;
      m_active = 1'b0;
      m_ptr = 0;
      m_t0 = 0;
      t = 0;
      for (int i = 0; i < NREQ; i++) drop_next[i] = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      chk("reset_cnt_in", 32'(cnt_in), 0);
      @(posedge clk);
      #2 rst = 1'b0;

      repeat (6) run_cycle(1'b0, 4'b0001, 16'h0003);
      repeat (3) run_cycle(1'b0, 4'b0000, 16'h0000);
      repeat (19) run_cycle(1'b0, 4'b0010, 16'h0000);
      repeat (2) run_cycle(1'b0, 4'b0000, 16'h0000);
      repeat (2) run_cycle(1'b0, 4'b0010, 16'h0010);
      repeat (3) run_cycle(1'b0, 4'b0010, 16'h0050);
      repeat (3) run_cycle(1'b0, 4'b0000, 16'h0000);
      repeat (5) run_cycle(1'b0, 4'b0101, 16'h0202);
      repeat (30) run_cycle(1'b0, 4'b1111, 16'h2222);
      repeat (3) run_cycle(1'b0, 4'b0000, 16'h0000);
      repeat (4) run_cycle(1'b0, 4'b1000, 16'h3000);
      do_reset_mid();
      repeat (10) run_cycle(1'b0, 4'b1000, 16'h3000);

      for (int c = 0; c < 4000; c++) begin
         run_cycle(1'b1, '0, '0);
         if (c % 1000 == 500) do_reset_mid();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
